cve2_mem_arbiter: RTL and testbench



---
 rtl/cve2_mem_arbiter.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_cve2_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cve2_mem_arbiter
//
// Shares one req/gnt/rvalid memory port between the core's instruction-fetch
// and data (load/store) interfaces. New requests are arbitrated
// combinationally, with data winning when both ask. A requester that is put
// on the bus but not granted is locked as owner until the grant arrives. Each
// granted transaction pushes its source (0 = instr, 1 = data) into a small
// FIFO, so in-order responses can be steered back to the requester that
// issued them.
//
// Optional feature (compile-time macro CVE2_ARB_STARVE_GUARD_EN):
//   Counts consecutive contested data wins. After StarveLimit of them, the
//   next contested arbitration is given to instruction fetch.
//
// Parameters:
//   MaxOutstanding : granted-but-unanswered bus transactions (power of two, >=1)
//   StarveLimit    : contested data wins before instr is forced (guard only, >=1)
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   instr_req_i/gnt_o/rvalid_o   fetch handshake
//   instr_addr_i                 fetch address
//   instr_rdata_o/err_o          fetch response payload (bus pass-through)
//   data_req_i/gnt_o/rvalid_o    load/store handshake
//   data_we_i/be_i/addr_i/wdata_i  load/store request payload
//   data_rdata_o/err_o           load/store response payload (bus pass-through)
//   bus_req_o/gnt_i/rvalid_i     shared memory handshake
//   bus_we_o/be_o/addr_o/wdata_o shared request payload (zero when idle)
//   bus_rdata_i/err_i            shared response payload
//   protocol_err_o               sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,

  output logic        protocol_err_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  localparam logic SRC_INSTR = 1'b0;
  localparam logic SRC_DATA  = 1'b1;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Pointer increment with wrap at MaxOutstanding (which need not fill PtrW).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] nxt;
    if (ptr == LastPtr) begin
      nxt = {PtrW{1'b0}};
    end else begin
      nxt = ptr + PtrW'(1);
    end
    return nxt;
  endfunction

  arb_state_e      state_r;
  arb_state_e      state_next_s;
  logic            owner_r;
  logic            owner_next_s;

  logic            fifo_r [MaxOutstanding];
  logic [PtrW-1:0] rd_ptr_r;
  logic [PtrW-1:0] wr_ptr_r;
  logic [CntW-1:0] count_r;

  logic            full_s;
  logic            empty_s;
  logic            head_s;
  logic            bus_req_s;
  logic            sel_s;
  logic            push_s;
  logic            pop_s;
  logic            force_instr_s;
  logic            protocol_err_r;

  assign full_s  = (count_r == MaxCnt);
  assign empty_s = (count_r == {CntW{1'b0}});
  assign head_s  = fifo_r[rd_ptr_r];

`ifdef CVE2_ARB_STARVE_GUARD_EN
  localparam int unsigned StW = $clog2(StarveLimit + 1);

  logic [StW-1:0] starve_cnt_r;

  assign force_instr_s = (starve_cnt_r >= StW'(StarveLimit));

  // Starvation counter: bumps on contested data wins, clears on any instr win.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_r <= {StW{1'b0}};
    end else if ((state_r == ARB_IDLE) && bus_req_s) begin
      if (sel_s == SRC_INSTR) begin
        starve_cnt_r <= {StW{1'b0}};
      end else if (instr_req_i) begin
        starve_cnt_r <= starve_cnt_r + StW'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end
`else
  // StarveLimit is always >= 1, so this stays low: strict data priority.
  assign force_instr_s = (StarveLimit == 32'd0);
`endif

  // Arbitration and owner-lock next state; selects which requester drives the bus.
  always_comb begin
    bus_req_s    = 1'b0;
    sel_s        = SRC_INSTR;
    state_next_s = state_r;
    owner_next_s = owner_r;
    case (state_r)
      ARB_IDLE: begin
        if (!full_s && (instr_req_i || data_req_i)) begin
          bus_req_s = 1'b1;
          if (data_req_i && !(instr_req_i && force_instr_s)) begin
            sel_s = SRC_DATA;
          end else begin
            sel_s = SRC_INSTR;
          end
          if (!bus_gnt_i) begin
            state_next_s = ARB_LOCKED;
            owner_next_s = sel_s;
          end else begin
            state_next_s = ARB_IDLE;
          end
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        // The owner stays on the bus even if it dropped its request.
        if (!full_s) begin
          bus_req_s = 1'b1;
          sel_s     = owner_r;
          if (bus_gnt_i) begin
            state_next_s = ARB_IDLE;
          end else begin
            state_next_s = ARB_LOCKED;
          end
        end else begin
          state_next_s = ARB_LOCKED;
        end
      end
      default: begin
        state_next_s = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state and owner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ARB_IDLE;
      owner_r <= SRC_INSTR;
    end else begin
      state_r <= state_next_s;
      owner_r <= owner_next_s;
    end
  end

  assign push_s = bus_req_s & bus_gnt_i;
  assign pop_s  = bus_rvalid_i & ~empty_s;

  // Source FIFO: records who owns each outstanding transaction, in issue order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MaxOutstanding); i++) begin
        fifo_r[i] <= 1'b0;
      end
      rd_ptr_r <= {PtrW{1'b0}};
      wr_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (push_s) begin
        fifo_r[wr_ptr_r] <= sel_s;
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end else begin
        wr_ptr_r         <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      protocol_err_r <= 1'b0;
    end else if (bus_rvalid_i && empty_s) begin
      protocol_err_r <= 1'b1;
    end else begin
      protocol_err_r <= protocol_err_r;
    end
  end

  // Request payload mux; zero whenever nothing is driven onto the bus.
  always_comb begin
    bus_we_o    = 1'b0;
    bus_be_o    = 4'h0;
    bus_addr_o  = 32'h0000_0000;
    bus_wdata_o = 32'h0000_0000;
    if (bus_req_s) begin
      if (sel_s == SRC_DATA) begin
        bus_we_o    = data_we_i;
        bus_be_o    = data_be_i;
        bus_addr_o  = data_addr_i;
        bus_wdata_o = data_wdata_i;
      end else begin
        bus_we_o    = 1'b0;
        bus_be_o    = 4'hF;
        bus_addr_o  = instr_addr_i;
        bus_wdata_o = 32'h0000_0000;
      end
    end else begin
      bus_we_o    = 1'b0;
      bus_be_o    = 4'h0;
      bus_addr_o  = 32'h0000_0000;
      bus_wdata_o = 32'h0000_0000;
    end
  end

  assign bus_req_o      = bus_req_s;
  assign instr_gnt_o    = push_s & (sel_s == SRC_INSTR);
  assign data_gnt_o     = push_s & (sel_s == SRC_DATA);

  // A response with an empty FIFO is reported, not forwarded.
  assign instr_rvalid_o = pop_s & (head_s == SRC_INSTR);
  assign data_rvalid_o  = pop_s & (head_s == SRC_DATA);

  assign instr_rdata_o  = bus_rdata_i;
  assign instr_err_o    = bus_err_i;
  assign data_rdata_o   = bus_rdata_i;
  assign data_err_o     = bus_err_i;

  assign protocol_err_o = protocol_err_r;

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
module tb_cve2_mem_arbiter;

  localparam int MAXO = 2;
  localparam int SLIM = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        bus_req_o, bus_gnt_i, bus_rvalid_i, bus_we_o, bus_err_i;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        protocol_err_o;

  always #5 clk_i = ~clk_i;

  cve2_mem_arbiter #(.MaxOutstanding(MAXO), .StarveLimit(SLIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .protocol_err_o(protocol_err_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: who owns each outstanding transaction, lock, starvation.
  bit src_q[$];
  bit lk_v;
  bit lk_own;
  int starve;
  bit perr_m;

  // Expected outputs for the current cycle.
  logic        e_req, e_sel, e_ig, e_dg, e_irv, e_drv, e_we;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata;

  // Observed snapshots taken at the sample point.
  logic        o_breq, o_ig, o_dg, o_irv, o_drv, o_perr;
  logic [31:0] o_addr, o_ird;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit head;
    e_req = 1'b0;
    e_sel = 1'b0;
    if (src_q.size() < MAXO) begin
      if (lk_v) begin
        e_req = 1'b1; e_sel = lk_own;
      end else if (instr_req_i && data_req_i) begin
        e_req = 1'b1;
`ifdef CVE2_ARB_STARVE_GUARD_EN
        e_sel = (starve >= SLIM) ? 1'b0 : 1'b1;
`else
        e_sel = 1'b1;
`endif
      end else if (data_req_i) begin
        e_req = 1'b1; e_sel = 1'b1;
      end else if (instr_req_i) begin
        e_req = 1'b1; e_sel = 1'b0;
      end
    end
    e_ig = e_req && !e_sel && bus_gnt_i;
    e_dg = e_req && e_sel && bus_gnt_i;
    e_irv = 1'b0;
    e_drv = 1'b0;
    if (bus_rvalid_i && src_q.size() > 0) begin
      head  = src_q[0];
      e_irv = !head;
      e_drv = head;
    end
    if (!e_req) begin
      e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    end else if (e_sel) begin
      e_we = data_we_i; e_be = data_be_i; e_addr = data_addr_i; e_wdata = data_wdata_i;
    end else begin
      e_we = 1'b0; e_be = 4'hF; e_addr = instr_addr_i; e_wdata = 32'h0;
    end
  endtask

  task automatic model_update();
    if (rst_i) begin
      src_q.delete(); lk_v = 1'b0; lk_own = 1'b0; starve = 0; perr_m = 1'b0;
    end else begin
      if (!lk_v && e_req) begin
        if (instr_req_i && data_req_i) starve = e_sel ? starve + 1 : 0;
        else if (!e_sel) starve = 0;
      end
      if (bus_rvalid_i) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        else perr_m = 1'b1;
      end
      if (e_req && bus_gnt_i) src_q.push_back(e_sel);
      lk_v   = e_req && !bus_gnt_i;
      lk_own = e_sel;
    end
  endtask

  // One clock cycle: sample/compare on the falling edge, step the model, return after the rising edge.
  task automatic tick(input bit chk);
    @(negedge clk_i);
    model_eval();
    o_breq = bus_req_o; o_ig = instr_gnt_o; o_dg = data_gnt_o;
    o_irv = instr_rvalid_o; o_drv = data_rvalid_o; o_perr = protocol_err_o;
    o_addr = bus_addr_o; o_ird = instr_rdata_o;
    if (chk) begin
      check("bus_req", bus_req_o, e_req);
      check("bus_addr", bus_addr_o, e_addr);
      check("bus_we", bus_we_o, e_we);
      check("bus_be", bus_be_o, e_be);
      check("bus_wdata", bus_wdata_o, e_wdata);
      check("instr_gnt", instr_gnt_o, e_ig);
      check("data_gnt", data_gnt_o, e_dg);
      check("instr_rvalid", instr_rvalid_o, e_irv);
      check("data_rvalid", data_rvalid_o, e_drv);
      check("protocol_err", protocol_err_o, perr_m);
      check("instr_rdata", instr_rdata_o, bus_rdata_i);
      check("data_rdata", data_rdata_o, bus_rdata_i);
      check("instr_err", instr_err_o, bus_err_i);
      check("data_err", data_err_o, bus_err_i);
    end
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit exp_d;
    rst_i = 1'b1;
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0; bus_err_i = 1'b0;
    lk_v = 1'b0; lk_own = 1'b0; starve = 0; perr_m = 1'b0;
    @(posedge clk_i);
    #1;
    tick(1'b0);
    tick(1'b0);
    rst_i = 1'b0;

    // Reset state with idle inputs
    tick(1'b1);
    check("reset_bus_req", o_breq, 32'd0);
    check("reset_perr", o_perr, 32'd0);
    check("reset_gnts", {o_ig, o_dg}, 32'd0);
    check("reset_addr", o_addr, 32'd0);

    // Single fetch
    instr_req_i = 1'b1; instr_addr_i = 32'h80; bus_gnt_i = 1'b1;
    tick(1'b1);
    check("fetch_gnt", o_ig, 32'd1);
    check("fetch_addr", o_addr, 32'h80);
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    tick(1'b1);
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEADBEEF;
    tick(1'b1);
    check("fetch_rvalid", o_irv, 32'd1);
    check("fetch_rdata", o_ird, 32'hDEADBEEF);
    check("fetch_no_data_rvalid", o_drv, 32'd0);
    bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;
    tick(1'b1);

    // Contention with grant held low, then in-order responses
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b1;
    data_be_i = 4'h3; data_wdata_i = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      check("cont_addr_data", o_addr, 32'h2000);
      check("cont_no_instr_gnt", o_ig, 32'd0);
    end
    bus_gnt_i = 1'b1;
    tick(1'b1);
    check("cont_data_gnt", o_dg, 32'd1);
    data_req_i = 1'b0; data_we_i = 1'b0;
    tick(1'b1);
    check("cont_instr_gnt_after", o_ig, 32'd1);
    check("cont_instr_addr", o_addr, 32'h100);
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hA;
    tick(1'b1);
    check("order_first_data", o_drv, 32'd1);
    check("order_first_not_instr", o_irv, 32'd0);
    bus_rdata_i = 32'hB;
    tick(1'b1);
    check("order_second_instr", o_irv, 32'd1);
    check("order_second_not_data", o_drv, 32'd0);
    bus_rvalid_i = 1'b0;
    tick(1'b1);

    // Full FIFO blocks a third request until the first response
    data_req_i = 1'b1; data_addr_i = 32'h3000;
    instr_req_i = 1'b1; instr_addr_i = 32'h200; bus_gnt_i = 1'b1;
    tick(1'b1);
    data_req_i = 1'b0;
    tick(1'b1);
    instr_addr_i = 32'h204;
    tick(1'b1);
    check("full_no_bus_req", o_breq, 32'd0);
    check("full_no_instr_gnt", o_ig, 32'd0);
    bus_rvalid_i = 1'b1;
    tick(1'b1);
    check("full_pop_cycle_no_req", o_breq, 32'd0);
    bus_rvalid_i = 1'b0;
    tick(1'b1);
    check("full_reassert", o_breq, 32'd1);
    check("full_reassert_gnt", o_ig, 32'd1);
    check("full_reassert_addr", o_addr, 32'h204);
    instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1;
    tick(1'b1);
    tick(1'b1);
    bus_rvalid_i = 1'b0;
    tick(1'b1);

    // Spurious response sets a sticky error that only reset clears
    bus_rvalid_i = 1'b1;
    tick(1'b1);
    bus_rvalid_i = 1'b0;
    tick(1'b1);
    check("perr_set", o_perr, 32'd1);
    tick(1'b1);
    check("perr_sticky", o_perr, 32'd1);
    rst_i = 1'b1;
    tick(1'b1);
    rst_i = 1'b0;
    tick(1'b1);
    check("perr_cleared", o_perr, 32'd0);

    // Continuous contention: grant pattern
    data_req_i = 1'b1; instr_req_i = 1'b1; bus_gnt_i = 1'b1;
    data_addr_i = 32'h4000; instr_addr_i = 32'h300;
    for (int i = 0; i < 10; i++) begin
      bus_rvalid_i = (src_q.size() > 0);
`ifdef CVE2_ARB_STARVE_GUARD_EN
      exp_d = ((i % 5) != 4);
`else
      exp_d = 1'b1;
`endif
      tick(1'b1);
      check("contend_pattern", {o_dg, o_ig}, exp_d ? 32'd2 : 32'd1);
    end
    data_req_i = 1'b0; instr_req_i = 1'b0; bus_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_rvalid_i = (src_q.size() > 0);
      tick(1'b1);
    end
    bus_rvalid_i = 1'b0;

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 299) == 0);
      if (!instr_req_i) begin
        instr_req_i  = ($urandom_range(0, 2) != 0);
        instr_addr_i = $urandom;
      end
      if (!data_req_i) begin
        data_req_i   = ($urandom_range(0, 1) != 0);
        data_addr_i  = $urandom;
        data_we_i    = ($urandom_range(0, 1) != 0);
        data_be_i    = 4'($urandom_range(0, 15));
        data_wdata_i = $urandom;
      end
      bus_gnt_i    = ($urandom_range(0, 3) != 0);
      bus_rvalid_i = (src_q.size() > 0) && ($urandom_range(0, 1) != 0);
      bus_rdata_i  = $urandom;
      bus_err_i    = ($urandom_range(0, 1) != 0);
      tick(1'b1);
      if (e_ig || rst_i) instr_req_i = 1'b0;
      if (e_dg || rst_i) data_req_i = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
